// File: rtl/hex_display_pkg.sv
// Shared constants for the seven-segment display peripheral: register map,
// CTRL field positions and the active-high hex segment table.
package hex_display_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_ADD    = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_LZB      = 1;
    localparam int unsigned CTRL_BLINK    = 2;
    localparam int unsigned CTRL_MASK_LSB = 8;

    localparam logic [15:0] CTRL_RESET = 16'h0001;

    // Segment order gfedcba; entry 15 is leftmost.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex_digit_decoder.sv
// Combinational nibble to seven-segment decoder, optionally active-low.
module hex_digit_decoder
    import hex_display_pkg::*;
#(
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = (ACTIVE_LOW != 0) ? ~SEG_TABLE[nibble] : SEG_TABLE[nibble];
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Memory-mapped NUM_DIGITS seven-segment display with DATA/CTRL/ADD/STATUS
// registers, leading-zero blanking, per-digit masking and a blink timer.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned BLINK_DIV  = 25_000_000,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    chipSelect,
    input  logic                    write,
    input  logic                    read,
    input  logic [1:0]              address,
    input  logic [31:0]             writeData,
    output logic [31:0]             readData,
    output logic [NUM_DIGITS*7-1:0] hex
);

    localparam int unsigned DW = NUM_DIGITS * 4;
    localparam int unsigned CW = $clog2(BLINK_DIV);
    localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [DW-1:0]           data_q, data_d;
    logic [15:0]             ctrl_q, ctrl_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    phase_q, phase_d;
    logic [31:0]             rdata_d;
    logic [NUM_DIGITS*7-1:0] hex_d;
    logic [2:0]              top_idx;
    logic                    wr_en, rd_en;
    logic                    unused;

    assign wr_en  = chipSelect & write;
    assign rd_en  = chipSelect & read;
    assign unused = ^writeData;

    always_comb begin
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;

        if (ctrl_q[CTRL_BLINK]) begin
            if (cnt_q == CW'(BLINK_DIV - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end

        // A CTRL write restarts the blink sequence from the visible phase.
        if (wr_en) begin
            case (address)
                ADDR_DATA: data_d = writeData[DW-1:0];
                ADDR_CTRL: begin
                    ctrl_d  = writeData[15:0];
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end
                ADDR_ADD:  data_d = data_q + writeData[DW-1:0];
                default:   ;
            endcase
        end
    end

    always_comb begin
        rdata_d = readData;
        if (rd_en) begin
            case (address)
                ADDR_DATA, ADDR_ADD: rdata_d = 32'(data_q);
                ADDR_CTRL:           rdata_d = {16'h0, ctrl_q};
                default:             rdata_d = {31'h0, phase_q};
            endcase
        end
    end

    always_comb begin
        top_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (data_q[4*i +: 4] != 4'h0) top_idx = 3'(i);
        end
    end

    logic [NUM_DIGITS-1:0][6:0] seg;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic visible;

        hex_digit_decoder #(
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_dec (
            .nibble(data_q[4*g +: 4]),
            .seg   (seg[g])
        );

        assign visible = ctrl_q[CTRL_EN] & ~ctrl_q[CTRL_MASK_LSB + g]
                       & ~(ctrl_q[CTRL_BLINK] & phase_q)
                       & ~(ctrl_q[CTRL_LZB] & (g > int'(top_idx)));
        assign hex_d[7*g +: 7] = visible ? seg[g] : SEG_OFF;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q   <= '0;
            ctrl_q   <= CTRL_RESET;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            readData <= '0;
            hex      <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            readData <= rdata_d;
            hex      <= hex_d;
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl: directed scenarios plus random bus
// traffic checked against a behavioural display model.
module tb_hex_display_ctrl;

    localparam int ND = 6;
    localparam int BD = 4;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [41:0] ALL_OFF = {42{1'b1}};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wd = 32'h0;
    logic [31:0] rdata;
    logic [41:0] hex;

    int total = 0;
    int bad   = 0;

    hex_display_ctrl #(
        .NUM_DIGITS(ND),
        .BLINK_DIV (BD),
        .ACTIVE_LOW(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .chipSelect(cs),
        .write     (wr),
        .read      (rd),
        .address   (addr),
        .writeData (wd),
        .readData  (rdata),
        .hex       (hex)
    );

    always #5 clk = ~clk;

    // Model state: t counts blink-enabled cycles since the last CTRL write.
    logic [23:0] m_data = 24'h0;
    logic [15:0] m_ctrl = 16'h1;
    int          m_t    = 0;
    logic [41:0] exp_hex = ALL_OFF;
    logic [31:0] rd_q[$];

    function automatic logic [41:0] model_hex(input logic [23:0] d, input logic [15:0] c,
                                              input int t);
        logic [41:0] h;
        int          top;
        bit          ph;
        bit          vis;
        logic [3:0]  nib;
        ph  = ((t / BD) % 2) != 0;
        top = 0;
        for (int i = 0; i < ND; i++) if (d[4*i +: 4] != 4'h0) top = i;
        for (int i = 0; i < ND; i++) begin
            nib = d[4*i +: 4];
            vis = c[0] && !c[8+i] && !(c[2] && ph) && !(c[1] && i > top);
            h[7*i +: 7] = vis ? ~SEG_TAB[nib] : 7'h7F;
        end
        return h;
    endfunction

    initial begin
        int nxt_t;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_data  = 24'h0;
                m_ctrl  = 16'h1;
                m_t     = 0;
                exp_hex = ALL_OFF;
                rd_q.delete();
            end else begin
                exp_hex = model_hex(m_data, m_ctrl, m_t);
                if (cs && rd) begin
                    case (addr)
                        2'd1:    rd_q.push_back({16'h0, m_ctrl});
                        2'd3:    rd_q.push_back({31'h0, ((m_t / BD) % 2) != 0});
                        default: rd_q.push_back({8'h0, m_data});
                    endcase
                end
                nxt_t = m_ctrl[2] ? m_t + 1 : 0;
                if (cs && wr) begin
                    case (addr)
                        2'd0: m_data = wd[23:0];
                        2'd1: begin m_ctrl = wd[15:0]; nxt_t = 0; end
                        2'd2: m_data = m_data + wd[23:0];
                        default: ;
                    endcase
                end
                m_t = nxt_t;
            end
        end
    end

    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            total++;
            if (hex !== exp_hex) begin
                bad++;
                $display("FAIL hex_scoreboard t=%0t got=%h want=%h", $time, hex, exp_hex);
            end
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                total++;
                if (rdata !== e) begin
                    bad++;
                    $display("FAIL read_scoreboard t=%0t got=%h want=%h", $time, rdata, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [41:0] got, input logic [41:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic bus(input logic w, input logic r, input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; wr = w; rd = r; addr = a; wd = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b0;
        #1;
        chk("reset_hex", hex, ALL_OFF);
        chk("reset_rdata", 42'(rdata), 42'h0);
        idle(2);
        rst = 1'b1;
        idle(1);

        // Plain decode.
        bus(1'b1, 1'b0, 2'd0, 32'h0065_4321);
        idle(1);
        chk("decode_654321", hex, {7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79});
        bus(1'b0, 1'b1, 2'd0, 32'h0);
        chk("read_data", 42'(rdata), 42'h65_4321);

        // Leading-zero blanking.
        bus(1'b1, 1'b0, 2'd1, 32'h3);
        bus(1'b1, 1'b0, 2'd0, 32'h42);
        idle(1);
        chk("lzb_42", hex, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});
        bus(1'b1, 1'b0, 2'd0, 32'h0);
        idle(1);
        chk("lzb_zero", hex, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});

        // Add with wrap.
        bus(1'b1, 1'b0, 2'd1, 32'h1);
        bus(1'b1, 1'b0, 2'd0, 32'h00FF_FFFF);
        bus(1'b1, 1'b0, 2'd2, 32'h1);
        idle(1);
        chk("add_wrap_hex", hex, {6{7'h40}});
        bus(1'b0, 1'b1, 2'd2, 32'h0);
        chk("add_wrap_read", 42'(rdata), 42'h0);
        bus(1'b1, 1'b0, 2'd2, 32'h10);
        bus(1'b0, 1'b1, 2'd0, 32'h0);
        chk("add_10_read", 42'(rdata), 42'h10);

        // Blink: visible for BD cycles then dark for BD cycles.
        bus(1'b1, 1'b0, 2'd1, 32'h5);
        idle(1);
        chk("blink_on", hex, {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h40});
        idle(4);
        chk("blink_off", hex, ALL_OFF);
        bus(1'b0, 1'b1, 2'd3, 32'h0);
        chk("status_phase1", 42'(rdata), 42'h1);
        idle(9);
        bus(1'b1, 1'b0, 2'd1, 32'h1);
        idle(2);
        bus(1'b0, 1'b1, 2'd3, 32'h0);
        chk("status_steady", 42'(rdata), 42'h0);

        // Masking plus read-during-write of CTRL.
        bus(1'b1, 1'b0, 2'd0, 32'h0065_4321);
        bus(1'b1, 1'b1, 2'd1, 32'h0000_2101);
        chk("rw_same_cycle", 42'(rdata), 42'h1);
        idle(1);
        chk("mask_0_5", hex, {7'h7F, 7'h12, 7'h19, 7'h30, 7'h24, 7'h7F});

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            logic [1:0]  a;
            logic [31:0] d;
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if (a == 2'd1) begin
                d[0] = ($urandom % 8) != 0;
                d[15:8] = ($urandom % 2 == 0) ? 8'h0 : d[15:8];
            end else begin
                d = d >> ($urandom % 32);
            end
            if ($urandom % 4 == 0) begin
                idle(1);
            end else begin
                bus(1'($urandom % 2), 1'($urandom % 2), a, d);
            end
        end

        // Reset during blink with a read in flight.
        bus(1'b1, 1'b0, 2'd0, 32'h0012_3456);
        bus(1'b1, 1'b0, 2'd1, 32'h5);
        idle(6);
        cs = 1'b1; rd = 1'b1; addr = 2'd0;
        @(posedge clk);
        #2 rst = 1'b0;
        cs = 1'b0; rd = 1'b0;
        #1;
        chk("midrst_hex", hex, ALL_OFF);
        chk("midrst_rdata", 42'(rdata), 42'h0);
        idle(2);
        rst = 1'b1;
        bus(1'b0, 1'b1, 2'd1, 32'h0);
        chk("post_rst_ctrl", 42'(rdata), 42'h1);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
